// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side and memory-side signals around the unified memory port.
//   slave  : the arbiter's view (serves fetch/data requesters, drives the memory request)
//   master : the environment's view (requesters plus the memory itself)
interface mem_port_arbiter_if;
    logic        ireq_valid;
    logic [31:0] ireq_addr;
    logic        iresp_ok;
    logic [31:0] iresp_data;

    logic        dreq_valid;
    logic [31:0] dreq_addr;
    logic        dreq_write;
    logic [3:0]  dreq_strobe;
    logic [31:0] dreq_wdata;
    logic        dresp_ok;
    logic [31:0] dresp_data;

    logic        mreq_valid;
    logic [31:0] mreq_addr;
    logic        mreq_write;
    logic [3:0]  mreq_strobe;
    logic [31:0] mreq_wdata;
    logic        mresp_ok;
    logic [31:0] mresp_data;

    modport slave (
        input  ireq_valid, ireq_addr,
        output iresp_ok, iresp_data,
        input  dreq_valid, dreq_addr, dreq_write, dreq_strobe, dreq_wdata,
        output dresp_ok, dresp_data,
        output mreq_valid, mreq_addr, mreq_write, mreq_strobe, mreq_wdata,
        input  mresp_ok, mresp_data
    );

    modport master (
        output ireq_valid, ireq_addr,
        input  iresp_ok, iresp_data,
        output dreq_valid, dreq_addr, dreq_write, dreq_strobe, dreq_wdata,
        input  dresp_ok, dresp_data,
        input  mreq_valid, mreq_addr, mreq_write, mreq_strobe, mreq_wdata,
        output mresp_ok, mresp_data
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port of the multi-cycle MIPS core between instruction fetch
// and data access. Registered-grant FSM, responses routed to the grant owner, plus a
// watchdog that force-completes transactions the memory never acknowledges.
// Build option: define MEM_ARB_RR_EN for round-robin arbitration on simultaneous
// requests; otherwise data always beats fetch.
//
// state  | meaning
// IDLE   | no transaction; arbitrates and latches the winner's request
// BUSY_I | fetch request presented to memory, waiting for mresp_ok or watchdog
// BUSY_D | data request presented to memory, waiting for mresp_ok or watchdog
module mem_port_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus,
    output logic              busy,
    output logic              timeout_err
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    // Width stays at least 1 so TIMEOUT=0 (watchdog off) still elaborates.
    localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;

    state_t          state;
    logic [WD_W-1:0] wd_cnt;
    logic            grant_d;
    logic            wd_expire;
    logic            done;

`ifdef MEM_ARB_RR_EN
    logic last_grant;   // 0 = fetch granted last, 1 = data granted last

    // On a tie the requester that did not win last time takes the port.
    always_comb begin
        grant_d = bus.dreq_valid && (!bus.ireq_valid || !last_grant);
    end
`else
    // Fixed priority: data wins whenever it is requesting.
    always_comb begin
        grant_d = bus.dreq_valid;
    end
`endif

    // Transaction ends on a memory ack, or on watchdog expiry when no ack arrives.
    always_comb begin
        wd_expire = 1'b0;
        if ((TIMEOUT != 0) && (state != IDLE) && (wd_cnt == WD_LAST) && !bus.mresp_ok)
            wd_expire = 1'b1;
        done = (state != IDLE) && (bus.mresp_ok || wd_expire);
    end

    // Route the completion to the owner only; a forced completion returns zero data.
    always_comb begin
        bus.iresp_ok   = 1'b0;
        bus.iresp_data = '0;
        bus.dresp_ok   = 1'b0;
        bus.dresp_data = '0;
        if (!reset && done) begin
            if (state == BUSY_I) begin
                bus.iresp_ok   = 1'b1;
                bus.iresp_data = bus.mresp_ok ? bus.mresp_data : 32'h0;
            end else if (state == BUSY_D) begin
                bus.dresp_ok   = 1'b1;
                bus.dresp_data = bus.mresp_ok ? bus.mresp_data : 32'h0;
            end
        end
    end

    // Grant FSM with registered memory request, busy flag, watchdog and sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            bus.mreq_valid  <= 1'b0;
            bus.mreq_addr   <= '0;
            bus.mreq_write  <= 1'b0;
            bus.mreq_strobe <= '0;
            bus.mreq_wdata  <= '0;
            busy            <= 1'b0;
            timeout_err     <= 1'b0;
            wd_cnt          <= '0;
`ifdef MEM_ARB_RR_EN
            last_grant      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.ireq_valid || bus.dreq_valid) begin
                        if (grant_d) begin
                            state           <= BUSY_D;
                            bus.mreq_addr   <= bus.dreq_addr;
                            bus.mreq_write  <= bus.dreq_write;
                            bus.mreq_strobe <= bus.dreq_strobe;
                            bus.mreq_wdata  <= bus.dreq_wdata;
                        end else begin
                            state           <= BUSY_I;
                            bus.mreq_addr   <= bus.ireq_addr;
                            bus.mreq_write  <= 1'b0;
                            bus.mreq_strobe <= '0;
                            bus.mreq_wdata  <= '0;
                        end
                        bus.mreq_valid <= 1'b1;
                        busy           <= 1'b1;
                        wd_cnt         <= '0;
`ifdef MEM_ARB_RR_EN
                        last_grant     <= grant_d;
`endif
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (done) begin
                        state          <= IDLE;
                        bus.mreq_valid <= 1'b0;
                        busy           <= 1'b0;
                        if (wd_expire)
                            timeout_err <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                end
                default: begin
                    state          <= IDLE;
                    bus.mreq_valid <= 1'b0;
                    busy           <= 1'b0;
                end
            endcase
        end
    end
endmodule
